// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall vector layout, stop/continue
// encodings, control FSM states and reset polarity.
package pipe_ctrl_pkg;

    localparam int CtrlWidth = 6;

    localparam int PC_BIT  = 0;
    localparam int IF_BIT  = 1;
    localparam int ID_BIT  = 2;
    localparam int EX_BIT  = 3;
    localparam int MEM_BIT = 4;
    localparam int WB_BIT  = 5;

    localparam logic Stop     = 1'b1;
    localparam logic Continue = 1'b0;

    // Reset is asserted low.
    localparam logic RstEnable = 1'b0;

    typedef enum logic {
        CTRL_RUN  = 1'b0,
        CTRL_PEND = 1'b1
    } ctrl_state_e;

    // Stop every stage from PC up to and including top_bit; the stage
    // register just above the boundary then emits a bubble.
    function automatic logic [CtrlWidth-1:0] stop_upto(input int top_bit);
        logic [CtrlWidth-1:0] v;
        v = {CtrlWidth{Continue}};
        for (int i = 0; i < CtrlWidth; i++) begin
            if (i <= top_bit) v[i] = Stop;
        end
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline control hub: priority stall vector, EX branch redirect
// sequencing (with fetch-in-flight deferral), stall counter and timeout.
// Ports:
//   clk, rst (async, active low)
//   stallreq_if/id/ex/mem : per-stage stall requests
//   ex_branch_flag/target : taken branch resolved in EX
//   stall                 : per-stage stop vector (bit0 = PC .. bit5 = WB)
//   flush, pc_redirect    : kill if_id/id_ex and load redirect_pc into PC
//   redirect_pc           : redirect target
//   stall_cycles          : cycles with stall[PC] set (wrapping)
//   stall_timeout         : sticky, set after TIMEOUT consecutive stalls
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CTRL_W  = CtrlWidth,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              ex_branch_flag,
    input  logic [ADDR_W-1:0] ex_branch_target,
    output logic [CTRL_W-1:0] stall,
    output logic              flush,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       stall_cycles,
    output logic              stall_timeout
);

    localparam int RUN_W = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT);

    ctrl_state_e       r_state;
    ctrl_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_pend_pc;
    logic [ADDR_W-1:0] w_pend_nxt;

    logic              w_live;
    logic [CTRL_W-1:0] w_stall;
    logic              w_flush;
    logic [ADDR_W-1:0] w_rpc;

    logic [31:0]       r_stall_cycles;
    logic [RUN_W-1:0]  r_run;
    logic [RUN_W-1:0]  w_run_inc;
    logic              r_timeout;
    logic              w_stall_pc;

    // Outputs are forced quiet while reset is held, even though they are
    // combinational from the requests.
    assign w_live = (rst != RstEnable);

    // Stall vector: the highest stalled stage wins.
    always_comb begin
        w_stall = {CTRL_W{Continue}};
        if (w_live) begin
            priority case (1'b1)
                stallreq_mem: w_stall = CTRL_W'(stop_upto(MEM_BIT));
                stallreq_ex:  w_stall = CTRL_W'(stop_upto(EX_BIT));
                stallreq_id:  w_stall = CTRL_W'(stop_upto(ID_BIT));
                stallreq_if:  w_stall = CTRL_W'(stop_upto(IF_BIT));
                default:      w_stall = {CTRL_W{Continue}};
            endcase
        end
    end

    // Redirect FSM: state register.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_state   <= CTRL_RUN;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend_pc <= w_pend_nxt;
        end
    end

    // Redirect FSM: next state and outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend_pc;
        w_flush     = 1'b0;
        w_rpc       = '0;
        if (w_live) begin
            unique case (r_state)
                CTRL_RUN: begin
                    // A held EX re-presents the flag next cycle.
                    if (ex_branch_flag && !stallreq_mem && !stallreq_ex) begin
                        if (stallreq_if) begin
                            // Fetch in flight: defer until it lands.
                            w_state_nxt = CTRL_PEND;
                            w_pend_nxt  = ex_branch_target;
                        end else begin
                            w_flush = 1'b1;
                            w_rpc   = ex_branch_target;
                        end
                    end
                end
                CTRL_PEND: begin
                    // Any branch flag seen here comes from a killed slot.
                    if (!stallreq_if && !stallreq_mem) begin
                        w_flush     = 1'b1;
                        w_rpc       = r_pend_pc;
                        w_state_nxt = CTRL_RUN;
                    end
                end
                default: w_state_nxt = CTRL_RUN;
            endcase
        end
    end

    assign w_stall_pc = w_stall[PC_BIT];
    assign w_run_inc  = (r_run == RUN_MAX) ? r_run : r_run + 1'b1;

    // Stall-cycle counter and consecutive-stall timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_stall_cycles <= '0;
            r_run          <= '0;
            r_timeout      <= 1'b0;
        end else if (w_stall_pc == Stop) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
            r_run          <= w_run_inc;
            if (w_run_inc == RUN_MAX) r_timeout <= 1'b1;
        end else begin
            r_run <= '0;
        end
    end

    assign stall         = w_stall;
    assign flush         = w_flush;
    assign pc_redirect   = w_flush;
    assign redirect_pc   = w_rpc;
    assign stall_cycles  = r_stall_cycles;
    assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        sif, sid, sex, smem, br;
    logic [31:0] tgt;
    logic [5:0]  stall;
    logic        flush, pc_redirect, stall_timeout;
    logic [31:0] redirect_pc, stall_cycles;

    typedef struct {
        string       nm;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] rpc;
        logic [31:0] sc;
        logic        to;
    } exp_t;

    exp_t q[$];
    int   n_run;
    int   n_fail;

    pipe_ctrl #(
        .CTRL_W (6),
        .ADDR_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_if     (sif),
        .stallreq_id     (sid),
        .stallreq_ex     (sex),
        .stallreq_mem    (smem),
        .ex_branch_flag  (br),
        .ex_branch_target(tgt),
        .stall           (stall),
        .flush           (flush),
        .pc_redirect     (pc_redirect),
        .redirect_pc     (redirect_pc),
        .stall_cycles    (stall_cycles),
        .stall_timeout   (stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string f,
                       input logic [31:0] act, input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h required=%h", nm, f, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "stall", 32'(stall), 32'(e.st));
            chk(e.nm, "flush", 32'(flush), 32'(e.fl));
            chk(e.nm, "pc_redirect", 32'(pc_redirect), 32'(e.fl));
            chk(e.nm, "redirect_pc", redirect_pc, e.rpc);
            chk(e.nm, "stall_cycles", stall_cycles, e.sc);
            chk(e.nm, "stall_timeout", 32'(stall_timeout), 32'(e.to));
        end
    end

    // One vector per cycle: inputs {rst,if,id,ex,mem,br}, target,
    // then the expected outputs for that same cycle.
    task automatic step(input string nm, input logic [5:0] in,
                        input logic [31:0] t, input logic [5:0] es,
                        input logic ef, input logic [31:0] erpc,
                        input logic [31:0] esc, input logic eto);
        exp_t e;
        @(posedge clk);
        #1;
        {rst, sif, sid, sex, smem, br} = in;
        tgt = t;
        e.nm  = nm;
        e.st  = es;
        e.fl  = ef;
        e.rpc = erpc;
        e.sc  = esc;
        e.to  = eto;
        q.push_back(e);
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst = 1'b0;
        {sif, sid, sex, smem, br} = '0;
        tgt = '0;

        //      name      r i d e m b   target      stall     f rpc     sc    to
        step("rst_hold", 6'b011111, 32'h10, 6'b000000, 0, 32'h0,   0, 0);
        step("rst_rel",  6'b111110, 32'h0,  6'b011111, 0, 32'h0,   0, 0);
        step("rst2",     6'b000000, 32'h0,  6'b000000, 0, 32'h0,   0, 0);
        step("idle",     6'b100000, 32'h0,  6'b000000, 0, 32'h0,   0, 0);
        step("id_req",   6'b101000, 32'h0,  6'b000111, 0, 32'h0,   0, 0);
        step("id_done",  6'b100000, 32'h0,  6'b000000, 0, 32'h0,   1, 0);
        step("br_now",   6'b100001, 32'h40, 6'b000000, 1, 32'h40,  1, 0);
        step("br_after", 6'b100000, 32'h0,  6'b000000, 0, 32'h0,   1, 0);
        step("pend0",    6'b110001, 32'h80, 6'b000011, 0, 32'h0,   1, 0);
        step("pend1",    6'b110000, 32'h0,  6'b000011, 0, 32'h0,   2, 0);
        step("pend2",    6'b110001, 32'hC0, 6'b000011, 0, 32'h0,   3, 0);
        step("pend_out", 6'b100001, 32'h100,6'b000000, 1, 32'h80,  4, 0);
        step("pend_run", 6'b100000, 32'h0,  6'b000000, 0, 32'h0,   4, 0);
        step("br_exhld", 6'b100101, 32'h44, 6'b001111, 0, 32'h0,   4, 0);
        step("br_exgo",  6'b100001, 32'h44, 6'b000000, 1, 32'h44,  5, 0);
        step("pm_enter", 6'b110001, 32'h200,6'b000011, 0, 32'h0,   5, 0);
        step("pm_memhd", 6'b100010, 32'h0,  6'b011111, 0, 32'h0,   6, 0);
        step("pm_out",   6'b100000, 32'h0,  6'b000000, 1, 32'h200, 7, 0);
        step("mem_if",   6'b110010, 32'h0,  6'b011111, 0, 32'h0,   7, 0);
        step("if_only",  6'b110000, 32'h0,  6'b000011, 0, 32'h0,   8, 0);
        step("if_rel",   6'b100000, 32'h0,  6'b000000, 0, 32'h0,   9, 0);
        step("rst3",     6'b000000, 32'h0,  6'b000000, 0, 32'h0,   0, 0);
        step("to_idle",  6'b100000, 32'h0,  6'b000000, 0, 32'h0,   0, 0);
        step("to_ex0",   6'b100100, 32'h0,  6'b001111, 0, 32'h0,   0, 0);
        step("to_ex1",   6'b100100, 32'h0,  6'b001111, 0, 32'h0,   1, 0);
        step("to_ex2",   6'b100100, 32'h0,  6'b001111, 0, 32'h0,   2, 0);
        step("to_ex3",   6'b100100, 32'h0,  6'b001111, 0, 32'h0,   3, 0);
        step("to_ex4",   6'b100100, 32'h0,  6'b001111, 0, 32'h0,   4, 1);
        step("to_ex5",   6'b100100, 32'h0,  6'b001111, 0, 32'h0,   5, 1);
        step("to_rel",   6'b100000, 32'h0,  6'b000000, 0, 32'h0,   6, 1);
        step("to_stick", 6'b100000, 32'h0,  6'b000000, 0, 32'h0,   6, 1);
        step("rp_pend",  6'b110001, 32'h300,6'b000011, 0, 32'h0,   6, 1);
        step("rp_rst",   6'b000000, 32'h0,  6'b000000, 0, 32'h0,   0, 0);
        step("rp_drop",  6'b100000, 32'h0,  6'b000000, 0, 32'h0,   0, 0);
        step("pri_idif", 6'b111000, 32'h0,  6'b000111, 0, 32'h0,   0, 0);
        step("pri_exid", 6'b101100, 32'h0,  6'b001111, 0, 32'h0,   1, 0);
        step("pri_done", 6'b100000, 32'h0,  6'b000000, 0, 32'h0,   2, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_run++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
